// File: rtl/spi_alu_pkg.sv
// rtl/spi_alu_pkg.sv - shared types for the SPI ALU master
// Contents: opcode enum, FSM state enum, OP_FRAME_W, instruction-field struct.
// REG_FIELD_W is the stored width of the register-address fields and must be
// at least the REG_SIZE the top is built with.
package spi_alu_pkg;

  localparam int OP_FRAME_W  = 8;
  localparam int REG_FIELD_W = 10;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_TX,
    S_RX,
    S_WB,
    S_DONE
  } state_e;

  typedef struct packed {
    opcode_e                op;
    logic [REG_FIELD_W-1:0] ra;
    logic [REG_FIELD_W-1:0] rb;
    logic [REG_FIELD_W-1:0] rd;
  } instr_t;

endpackage

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - mode-0 SPI engine: SCLK divider, bit counter, shift registers
// Ports:
//   clock, reset    system clock, synchronous active-low reset
//   start           load tx_word and begin a TX_BITS+RX_BITS transfer
//   tx_word         outgoing frame, sent MSB first
//   miso            serial input, sampled on SCLK rising edges of the RX bits
//   sclk, mosi      serial clock (idles low) and serial output
//   rx_word         received bits, MSB first
//   tx_end          strobe on the clock that ends the last TX bit
//   xfer_end        strobe on the clock that ends the last RX bit
module spi_shifter #(
  parameter int CLK_DIV = 2,
  parameter int TX_BITS = 72,
  parameter int RX_BITS = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [TX_BITS-1:0] tx_word,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi,
  output logic [RX_BITS-1:0] rx_word,
  output logic               tx_end,
  output logic               xfer_end
);

  localparam int TOTAL = TX_BITS + RX_BITS;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(TOTAL) + 1;

  logic               busy;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [TX_BITS-1:0] sreg;
  logic               half_end;
  logic               fall;

  // A bit period is CLK_DIV clocks low then CLK_DIV clocks high; mosi moves
  // on the falling edge, which is the start of the next low half.
  assign half_end = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall     = half_end && sclk;
  assign tx_end   = fall && (bit_cnt == BIT_W'(TX_BITS - 1));
  assign xfer_end = fall && (bit_cnt == BIT_W'(TOTAL - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      rx_word <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      mosi    <= tx_word[TX_BITS-1];
      sreg    <= {tx_word[TX_BITS-2:0], 1'b0};
    end else if (busy) begin
      if (half_end) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (!sclk) begin
          if (bit_cnt >= BIT_W'(TX_BITS))
            rx_word <= {rx_word[RX_BITS-2:0], miso};
        end else begin
          // sreg drains to zeros, so mosi sits low through the RX bits
          mosi    <= sreg[TX_BITS-1];
          sreg    <= {sreg[TX_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (xfer_end) begin
            busy    <= 1'b0;
            mosi    <= 1'b0;
            bit_cnt <= '0;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_alu_master.sv
// rtl/spi_alu_master.sv - register-bank front end that ships ALU ops to an SPI slave
// Optional feature macro: SPI_PARITY_EN (extra even-parity bit on the result).
// Ports:
//   clock, reset           system clock, synchronous active-low reset
//   instr, instr_valid     {opcode, regA, regB, rd}; accepted when ready is high
//   ready, done, error     idle flag, completion pulse, parity-reject flag
//   wr_en/wr_addr/wr_data  host register preload, honoured only in IDLE
//   rd_addr, rd_data       combinational debug read of the bank
//   sclk, mosi, cs_n, miso SPI master pins
module spi_alu_master
  import spi_alu_pkg::*;
#(
  parameter int REG_SIZE = 10,
  parameter int DATA_W   = 32,
  parameter int CLK_DIV  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3+3*REG_SIZE-1:0] instr,
  input  logic                  instr_valid,
  output logic                  ready,
  output logic                  done,
  output logic                  error,
  input  logic                  wr_en,
  input  logic [REG_SIZE-1:0]   wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_SIZE-1:0]   rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  input  logic                  miso
);

`ifdef SPI_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int TX_BITS = OP_FRAME_W + 2 * DATA_W;
  localparam int RX_BITS = DATA_W + PAR_W;
  localparam int DEPTH   = 2 ** REG_SIZE;

  state_e              state;
  instr_t              cur;
  logic [DATA_W-1:0]   regbank [DEPTH];
  logic [REG_SIZE-1:0] ra_idx, rb_idx, rd_idx;
  logic                accept;
  logic [TX_BITS-1:0]  tx_word;
  logic [RX_BITS-1:0]  rx_word;
  logic [DATA_W-1:0]   result;
  logic                parity_bad;
  logic                tx_end, xfer_end;

  assign accept = instr_valid && ready && (state == S_IDLE);
  assign ra_idx = REG_SIZE'(cur.ra);
  assign rb_idx = REG_SIZE'(cur.rb);
  assign rd_idx = REG_SIZE'(cur.rd);
  assign rd_data = regbank[rd_addr];

  // Operands are taken straight from the bank while in READ; the shifter
  // loads them on the READ->TX edge, so a write in the accept cycle is seen.
  assign tx_word = {{(OP_FRAME_W - 3){1'b0}}, cur.op, regbank[ra_idx], regbank[rb_idx]};
  assign result  = rx_word[RX_BITS-1 -: DATA_W];

`ifdef SPI_PARITY_EN
  assign parity_bad = ^rx_word;
`else
  assign parity_bad = 1'b0;
`endif

  spi_shifter #(
    .CLK_DIV (CLK_DIV),
    .TX_BITS (TX_BITS),
    .RX_BITS (RX_BITS)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .start    (state == S_READ),
    .tx_word  (tx_word),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .rx_word  (rx_word),
    .tx_end   (tx_end),
    .xfer_end (xfer_end)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      ready <= 1'b0;
      done  <= 1'b0;
      cs_n  <= 1'b1;
      cur   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cur.op <= opcode_e'(instr[3*REG_SIZE +: 3]);
            cur.ra <= REG_FIELD_W'(instr[2*REG_SIZE +: REG_SIZE]);
            cur.rb <= REG_FIELD_W'(instr[REG_SIZE +: REG_SIZE]);
            cur.rd <= REG_FIELD_W'(instr[0 +: REG_SIZE]);
            state  <= S_READ;
            ready  <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        S_READ: begin
          state <= S_TX;
          cs_n  <= 1'b0;
        end
        S_TX: if (tx_end) state <= S_RX;
        S_RX: begin
          if (xfer_end) begin
            state <= S_WB;
            cs_n  <= 1'b1;
          end
        end
        S_WB: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regbank[i] <= '0;
    end else if (state == S_IDLE && wr_en) begin
      regbank[wr_addr] <= wr_data;
    end else if (state == S_WB && !parity_bad) begin
      regbank[rd_idx] <= result;
    end
  end

`ifdef SPI_PARITY_EN
  logic error_q;
  always_ff @(posedge clock) begin
    if (!reset)              error_q <= 1'b0;
    else if (accept)         error_q <= 1'b0;
    else if (state == S_WB)  error_q <= parity_bad;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
